// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion: one schedule word per clock, full schedule
// held in a word array for random-access round-key reads.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // Multiplicative inverse as a^254; zero maps to zero for free.
    always_comb begin
        inv = 8'h01;
        sq  = a;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) inv = gf_mul(inv, sq);
            sq = gf_mul(sq, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_schedule #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rk_round,
    output logic [127:0]        rk_out
);
    localparam int NK    = KEY_BITS / 32;
    localparam int NR    = NK + 6;
    localparam int TOTAL = 4 * (NR + 1);

    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_W    = 6'(TOTAL - 1);
    localparam logic [2:0] NK_LAST   = 3'(NK - 1);
    localparam logic [3:0] NR_R      = 4'(NR);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_EXPAND  = 1'b1;

    logic [31:0] w [TOTAL];
    logic [0:0]  state;
    logic [5:0]  idx;
    logic [2:0]  phase;
    logic [7:0]  rcon;

    logic [31:0] prev;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;
    logic [5:0]  rd_base;

    assign prev   = w[idx - 6'd1];
    assign sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .s (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (phase == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (NK == 8 && phase == 3'd4)
            temp = sub_out;
        new_word = w[idx - NK_W] ^ temp;
    end

    assign rd_base = (rk_round <= NR_R) ? {rk_round, 2'b00} : 6'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            idx        <= 6'd0;
            phase      <= 3'd0;
            rcon       <= 8'h01;
            rk_out     <= 128'h0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_EXPAND;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        idx        <= NK_W;
                        phase      <= 3'd0;
                        rcon       <= 8'h01;
                    end
                end
                S_EXPAND: begin
                    idx   <= idx + 6'd1;
                    phase <= (phase == NK_LAST) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (idx == LAST_W) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (rk_round <= NR_R)
                rk_out <= {w[rd_base], w[rd_base + 6'd1],
                           w[rd_base + 6'd2], w[rd_base + 6'd3]};
            else
                rk_out <= 128'h0;
        end
    end

    // Schedule storage is never cleared; keys_valid qualifies its contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_IDLE && start) begin
                for (int k = 0; k < NK; k++)
                    w[6'(k)] <= key_in[KEY_BITS-1-32*k -: 32];
            end else if (state == S_EXPAND) begin
                w[idx] <= new_word;
            end
        end
    end
endmodule
